// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file access controller.
//   RF_DATA_WIDTH  : register file word width
//   RF_ADDR_WIDTH  : register address width (32 registers)
//   rf_state_e     : controller states, one request in flight at a time
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package rf_pkg;

    localparam int RF_DATA_WIDTH     = 32;
    localparam int RF_ADDR_WIDTH     = 5;
    localparam int RF_TIMEOUT_CYCLES = 255;
    localparam int RF_TIMER_WIDTH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_CAP    = 3'd2,
        ST_OPV    = 3'd3,
        ST_WAITWB = 3'd4,
        ST_WR     = 3'd5
    } rf_state_e;

endpackage

// File: rtl/rf_wb_timer.sv
// -----------------------------------------------------------------------------
// rf_wb_timer
// Write-back wait timer. Only built when RF_WB_TIMEOUT_EN is defined.
// The count is held at zero while i_run is low, so it is already clear on the
// first cycle of a wait, then advances once per cycle while i_run is high.
// Ports:
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset
//   i_run    : high while the controller waits for a result
//   o_tc     : terminal count, high in the TIMEOUT_CYCLES-th waiting cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifdef RF_WB_TIMEOUT_EN
module rf_wb_timer
    import rf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = RF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = RF_TIMER_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_tc
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_run) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count starts at 0 in the first waiting cycle, so TIMEOUT_CYCLES-1
    // marks the last cycle of the allowed wait.
    assign o_tc = i_run && (r_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// rf_access_ctrl
// Initiator side of the 32x32 register file port. Takes one decoded
// instruction, reads both source operands, hands them to the ALU with a
// valid/ready handshake, then accepts the result and writes it back.
// Optional feature macro: RF_WB_TIMEOUT_EN (abandon a write-back that never
// arrives and pulse err).
// Ports:
//   CLK, RST            : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake; in_rs/in_rt/in_rd/in_wb payload
//   rf_read/rf_write    : register file strobes, never both high
//   rf_addr_r1/r2/w     : register file addresses
//   rf_data_w           : write data; rf_data_r1/r2 read data
//   op_valid/op_ready   : operand handshake toward the ALU; op_a/op_b operands
//   wb_valid/wb_ready   : result handshake from the ALU; wb_data result
//   err                 : one-cycle write-back timeout pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rf_access_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = RF_ADDR_WIDTH,
    parameter int ZERO_REG_PROT  = 1,
    parameter int TIMEOUT_CYCLES = RF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wb,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  err
);

    rf_state_e             r_state;
    rf_state_e             w_nextState;
    logic [ADDR_WIDTH-1:0] r_rs;
    logic [ADDR_WIDTH-1:0] r_rt;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_wb;
    logic [DATA_WIDTH-1:0] r_opA;
    logic [DATA_WIDTH-1:0] r_opB;
    logic [DATA_WIDTH-1:0] r_wbData;
    logic                  w_timeout;
    logic                  w_writeBlocked;

`ifdef RF_WB_TIMEOUT_EN
    rf_wb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (RF_TIMER_WIDTH)
    ) u_wb_timer (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_run   (r_state == ST_WAITWB),
        .o_tc    (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // A write-back to register 0 still walks through WR so the sequencing is
    // identical; only the strobe itself is withheld.
    assign w_writeBlocked = (ZERO_REG_PROT != 0) && (r_rd == '0);

    // State register plus all datapath captures.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_wb     <= 1'b0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_wbData <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && in_valid) begin
                r_rs <= in_rs;
                r_rt <= in_rt;
                r_rd <= in_rd;
                r_wb <= in_wb;
            end
            if (r_state == ST_CAP) begin
                r_opA <= rf_data_r1;
                r_opB <= rf_data_r2;
            end
            if (r_state == ST_WAITWB && wb_valid) begin
                r_wbData <= wb_data;
            end
        end
    end

    // Next-state and strobe decode. A result arriving in the same cycle as the
    // timeout still wins, since it is already valid.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        rf_read     = 1'b0;
        rf_write    = 1'b0;
        rf_addr_r1  = '0;
        rf_addr_r2  = '0;
        rf_addr_w   = '0;
        rf_data_w   = '0;
        op_valid    = 1'b0;
        wb_ready    = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by RST so every output reads 0 while reset is held.
                in_ready = RST;
                if (in_valid) w_nextState = ST_RD;
            end
            ST_RD: begin
                rf_read     = 1'b1;
                rf_addr_r1  = r_rs;
                rf_addr_r2  = r_rt;
                w_nextState = ST_CAP;
            end
            ST_CAP: begin
                rf_read     = 1'b1;
                rf_addr_r1  = r_rs;
                rf_addr_r2  = r_rt;
                w_nextState = ST_OPV;
            end
            ST_OPV: begin
                op_valid = 1'b1;
                if (op_ready) w_nextState = r_wb ? ST_WAITWB : ST_IDLE;
            end
            ST_WAITWB: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    w_nextState = ST_WR;
                end else if (w_timeout) begin
                    err         = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            ST_WR: begin
                rf_write    = !w_writeBlocked;
                rf_addr_w   = r_rd;
                rf_data_w   = r_wbData;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign op_a = r_opA;
    assign op_b = r_opB;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_access_ctrl
// Directed bench for rf_access_ctrl with a small register file attached.
// The register file reads synchronously while rf_read is high and writes on
// rf_write; reset loads r3=0x11 and r7=0x22, all other registers 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic        in_wb = 1'b0;
    logic        rf_read;
    logic        rf_write;
    logic [4:0]  rf_addr_r1;
    logic [4:0]  rf_addr_r2;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w;
    logic [31:0] rf_data_r1;
    logic [31:0] rf_data_r2;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] wb_data = '0;
    logic        err;

    logic [31:0] mem [32];
    int          writeCount = 0;
    int          errors = 0;
    int          checks = 0;

    rf_access_ctrl #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (5),
        .ZERO_REG_PROT  (1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_wb      (in_wb),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .rf_addr_r1 (rf_addr_r1),
        .rf_addr_r2 (rf_addr_r2),
        .rf_addr_w  (rf_addr_w),
        .rf_data_w  (rf_data_w),
        .rf_data_r1 (rf_data_r1),
        .rf_data_r2 (rf_data_r2),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    // Register file model attached to the controller's port.
    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[3]     <= 32'h11;
            mem[7]     <= 32'h22;
            rf_data_r1 <= '0;
            rf_data_r2 <= '0;
        end else begin
            if (rf_read) begin
                rf_data_r1 <= mem[rf_addr_r1];
                rf_data_r2 <= mem[rf_addr_r2];
            end
            if (rf_write) begin
                mem[rf_addr_w] <= rf_data_w;
                writeCount     <= writeCount + 1;
            end
        end
    end

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for a single accept edge; the controller is in RD after.
    task automatic issueReq(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic wb);
        in_valid = 1'b1;
        in_rs = rs; in_rt = rt; in_rd = rd; in_wb = wb;
        tick();
        in_valid = 1'b0;
    endtask

    // From RD, two edges reach OPV.
    task automatic runToOpv();
        tick();
        tick();
    endtask

    task automatic releaseOperands();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++;
        if ({rf_read, rf_write, op_valid, wb_ready, err} !== 5'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %05b want 00000", {rf_read, rf_write, op_valid, wb_ready, err}); end
        checks++;
        if ({op_a, op_b} !== 64'h0) begin errors++; $display("[TB] FAIL reset_operands: got %h/%h want 0/0", op_a, op_b); end
        checks++;
        RST = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %0b want 1", in_ready); end
        checks++;
    endtask

    task automatic test_read_no_wb();
        issueReq(5'd3, 5'd7, 5'd0, 1'b0);
        if ({rf_read, rf_addr_r1, rf_addr_r2} !== {1'b1, 5'd3, 5'd7}) begin errors++; $display("[TB] FAIL rd_cycle: got read=%0b r1=%0d r2=%0d want 1/3/7", rf_read, rf_addr_r1, rf_addr_r2); end
        checks++;
        if ({in_ready, op_valid, rf_write} !== 3'b000) begin errors++; $display("[TB] FAIL rd_cycle_quiet: got %03b want 000", {in_ready, op_valid, rf_write}); end
        checks++;
        tick();
        if ({rf_read, rf_addr_r1, rf_addr_r2} !== {1'b1, 5'd3, 5'd7}) begin errors++; $display("[TB] FAIL cap_cycle: got read=%0b r1=%0d r2=%0d want 1/3/7", rf_read, rf_addr_r1, rf_addr_r2); end
        checks++;
        tick();
        if ({op_valid, rf_read} !== 2'b10) begin errors++; $display("[TB] FAIL opv_flags: got valid=%0b read=%0b want 1/0", op_valid, rf_read); end
        checks++;
        if (op_a !== 32'h11 || op_b !== 32'h22) begin errors++; $display("[TB] FAIL opv_operands: got %h/%h want 00000011/00000022", op_a, op_b); end
        checks++;
        releaseOperands();
        if ({in_ready, op_valid, wb_ready} !== 3'b100) begin errors++; $display("[TB] FAIL no_wb_return: got %03b want 100", {in_ready, op_valid, wb_ready}); end
        checks++;
    endtask

    task automatic test_write_back();
        int startWrites;
        startWrites = writeCount;
        issueReq(5'd1, 5'd2, 5'd9, 1'b1);
        runToOpv();
        releaseOperands();
        if ({wb_ready, rf_write, in_ready, err} !== 4'b1000) begin errors++; $display("[TB] FAIL waitwb_flags: got %04b want 1000", {wb_ready, rf_write, in_ready, err}); end
        checks++;
        wb_valid = 1'b1;
        wb_data  = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        wb_data  = 32'h0;
        if ({rf_write, rf_read, rf_addr_w} !== {1'b1, 1'b0, 5'd9}) begin errors++; $display("[TB] FAIL wr_cycle: got write=%0b read=%0b addr=%0d want 1/0/9", rf_write, rf_read, rf_addr_w); end
        checks++;
        if (rf_data_w !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_data: got %h want deadbeef", rf_data_w); end
        checks++;
        tick();
        if ({rf_write, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL wr_return: got write=%0b ready=%0b want 0/1", rf_write, in_ready); end
        checks++;
        if (writeCount - startWrites !== 1) begin errors++; $display("[TB] FAIL wr_pulse_count: got %0d want 1", writeCount - startWrites); end
        checks++;
        issueReq(5'd9, 5'd0, 5'd0, 1'b0);
        runToOpv();
        if (op_a !== 32'hDEADBEEF || op_b !== 32'h0) begin errors++; $display("[TB] FAIL readback_r9: got %h/%h want deadbeef/00000000", op_a, op_b); end
        checks++;
        releaseOperands();
    endtask

    task automatic test_zero_reg();
        int startWrites;
        startWrites = writeCount;
        issueReq(5'd3, 5'd7, 5'd0, 1'b1);
        runToOpv();
        releaseOperands();
`ifdef RF_WB_TIMEOUT_EN
        if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_waitwb: got %0b want 1", wb_ready); end
        checks++;
`else
        for (int i = 0; i < 6; i++) tick();
        if ({wb_ready, err} !== 2'b10) begin errors++; $display("[TB] FAIL zero_long_wait: got ready=%0b err=%0b want 1/0", wb_ready, err); end
        checks++;
`endif
        wb_valid = 1'b1;
        wb_data  = 32'hCAFEF00D;
        tick();
        wb_valid = 1'b0;
        if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL zero_no_write: got %0b want 0", rf_write); end
        checks++;
        tick();
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready_back: got %0b want 1", in_ready); end
        checks++;
        if (writeCount != startWrites) begin errors++; $display("[TB] FAIL zero_write_count: got %0d want %0d", writeCount, startWrites); end
        checks++;
        issueReq(5'd0, 5'd3, 5'd0, 1'b0);
        runToOpv();
        if (op_a !== 32'h0 || op_b !== 32'h11) begin errors++; $display("[TB] FAIL zero_r0_intact: got %h/%h want 00000000/00000011", op_a, op_b); end
        checks++;
        releaseOperands();
    endtask

    task automatic test_stall();
        issueReq(5'd7, 5'd3, 5'd0, 1'b0);
        runToOpv();
        in_valid = 1'b1;
        in_rs    = 5'd1;
        for (int i = 0; i < 10; i++) begin
            if ({op_valid, in_ready} !== 2'b10) begin errors++; $display("[TB] FAIL stall_flags_%0d: got valid=%0b ready=%0b want 1/0", i, op_valid, in_ready); end
            checks++;
            if (op_a !== 32'h22 || op_b !== 32'h11) begin errors++; $display("[TB] FAIL stall_operands_%0d: got %h/%h want 00000022/00000011", i, op_a, op_b); end
            checks++;
            tick();
        end
        in_valid = 1'b0;
        releaseOperands();
        if ({in_ready, rf_read} !== 2'b10) begin errors++; $display("[TB] FAIL stall_release: got ready=%0b read=%0b want 1/0", in_ready, rf_read); end
        checks++;
    endtask

    task automatic test_reset_in_waitwb();
        int startWrites;
        issueReq(5'd3, 5'd7, 5'd5, 1'b1);
        runToOpv();
        releaseOperands();
        startWrites = writeCount;
        RST      = 1'b0;
        wb_valid = 1'b1;
        wb_data  = 32'h12345678;
        tick();
        wb_valid = 1'b0;
        if ({in_ready, rf_read, rf_write, op_valid, wb_ready, err} !== 6'b0) begin errors++; $display("[TB] FAIL rst_wb_outputs: got %06b want 000000", {in_ready, rf_read, rf_write, op_valid, wb_ready, err}); end
        checks++;
        if ({op_a, op_b, rf_addr_w, rf_data_w} !== 101'h0) begin errors++; $display("[TB] FAIL rst_wb_data: got a=%h b=%h aw=%0d dw=%h want all 0", op_a, op_b, rf_addr_w, rf_data_w); end
        checks++;
        RST = 1'b1;
        tick();
        tick();
        if (writeCount != startWrites) begin errors++; $display("[TB] FAIL rst_wb_no_write: got %0d writes want %0d", writeCount, startWrites); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_wb_idle: got %0b want 1", in_ready); end
        checks++;
    endtask

`ifdef RF_WB_TIMEOUT_EN
    task automatic test_timeout();
        int startWrites;
        int errCount;
        startWrites = writeCount;
        errCount    = 0;
        issueReq(5'd3, 5'd7, 5'd4, 1'b1);
        runToOpv();
        releaseOperands();
        for (int i = 1; i <= 4; i++) begin
            if (err !== (i == 4)) begin errors++; $display("[TB] FAIL timeout_err_cycle_%0d: got %0b want %0b", i, err, (i == 4)); end
            checks++;
            if (err === 1'b1) errCount++;
            tick();
        end
        if ({in_ready, err, rf_write} !== 3'b100) begin errors++; $display("[TB] FAIL timeout_return: got %03b want 100", {in_ready, err, rf_write}); end
        checks++;
        if (writeCount != startWrites || errCount != 1) begin errors++; $display("[TB] FAIL timeout_counts: got writes=%0d errs=%0d want %0d/1", writeCount - startWrites, errCount, 0); end
        checks++;
    endtask
`endif

    initial begin
        $display("[TB] rf_access_ctrl directed test start");
        test_reset();
        test_read_no_wb();
        test_write_back();
        test_zero_reg();
        test_stall();
`ifdef RF_WB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_waitwb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
